// File: rtl/row_group_ctrl.sv
// Row group sequencer: clear, address gen, tile read, drain and MISO pop per tile.
// Optional cycle counters and early-exit flag when ROW_GROUP_CTRL_PERF_EN is defined.
module row_group_ctrl #(
   parameter int ROUTER_COUNT    = 4,
   parameter int SRAM_ADDR_WIDTH = 8,
   parameter int WORD_CNT_WIDTH  = 8,
   parameter int SRAM_LATENCY    = 1
) (
   input  logic                       i_clk,
   input  logic                       i_nrst,
   input  logic                       i_start,
   input  logic                       i_abort,
   input  logic [SRAM_ADDR_WIDTH-1:0] i_base_addr,
   input  logic [WORD_CNT_WIDTH-1:0]  i_tile_words,
   input  logic                       i_ag_valid,
   input  logic                       i_addr_empty,
   input  logic                       i_data_empty,
   output logic                       o_reg_clear,
   output logic                       o_ag_en,
   output logic [ROUTER_COUNT-1:0]    o_row_id,
   output logic                       o_ac_en,
   output logic                       o_sram_rd_en,
   output logic [SRAM_ADDR_WIDTH-1:0] o_sram_addr,
   output logic                       o_miso_pop_en,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_miss
`ifdef ROW_GROUP_CTRL_PERF_EN
  ,output logic [15:0]                o_cyc_read,
   output logic [15:0]                o_cyc_pop,
   output logic                       o_early_exit
`endif
);

   localparam int DW = $clog2(SRAM_LATENCY + 2);
   localparam int PW = $clog2(ROUTER_COUNT + 1) + 1;

   localparam logic [ROUTER_COUNT-1:0]   ROW_LAST = ROUTER_COUNT'(ROUTER_COUNT - 1);
   localparam logic [WORD_CNT_WIDTH-1:0] WORD_ONE = WORD_CNT_WIDTH'(1);
   localparam logic [DW-1:0]             DLY_LAST = DW'(SRAM_LATENCY);
   localparam logic [PW-1:0]             POP_RDY  = PW'(ROUTER_COUNT);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_GEN, S_READ, S_DRAIN, S_POP, S_DONE, S_ABORT
   } state_t;

   state_t                      state, state_nxt;
   logic [ROUTER_COUNT-1:0]     row_cnt, row_nxt;
   logic [WORD_CNT_WIDTH-1:0]   word_cnt, word_nxt;
   logic [DW-1:0]               dly_cnt, dly_nxt;
   logic [PW-1:0]               pop_cnt, pop_nxt;
   logic [SRAM_ADDR_WIDTH-1:0]  base_q, base_nxt;
   logic [WORD_CNT_WIDTH-1:0]   words_q, words_nxt;
   logic                        miss_q, miss_nxt;
   logic [WORD_CNT_WIDTH-1:0]   last_word;
   logic                        abort_ok;

   assign last_word = words_q - WORD_ONE;
   assign abort_ok  = i_abort && (state != S_IDLE) &&
                      (state != S_CLEAR) && (state != S_ABORT);

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state    <= S_IDLE;
         row_cnt  <= '0;
         word_cnt <= '0;
         dly_cnt  <= '0;
         pop_cnt  <= '0;
         base_q   <= '0;
         words_q  <= '0;
         miss_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         row_cnt  <= row_nxt;
         word_cnt <= word_nxt;
         dly_cnt  <= dly_nxt;
         pop_cnt  <= pop_nxt;
         base_q   <= base_nxt;
         words_q  <= words_nxt;
         miss_q   <= miss_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      row_nxt   = row_cnt;
      word_nxt  = word_cnt;
      dly_nxt   = dly_cnt;
      pop_nxt   = pop_cnt;
      base_nxt  = base_q;
      words_nxt = words_q;
      miss_nxt  = miss_q;
      if (abort_ok) begin
         state_nxt = S_ABORT;
      end else begin
         unique case (state)
            S_IDLE: if (i_start) begin
               base_nxt  = i_base_addr;
               words_nxt = i_tile_words;
               miss_nxt  = 1'b0;
               state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
               row_nxt   = '0;
               state_nxt = S_GEN;
            end
            S_GEN: if (i_ag_valid) begin
               if (row_cnt == ROW_LAST) begin
                  word_nxt = '0;
                  pop_nxt  = '0;
                  if (words_q == '0) begin
                     miss_nxt  = 1'b1;
                     state_nxt = S_POP;
                  end else begin
                     state_nxt = S_READ;
                  end
               end else begin
                  row_nxt = row_cnt + 1'b1;
               end
            end
            // word_cnt==0 marks the first read, where addr_empty is stale
            S_READ: begin
               if ((word_cnt != '0 && i_addr_empty) || word_cnt == last_word) begin
                  dly_nxt   = '0;
                  state_nxt = S_DRAIN;
               end else begin
                  word_nxt = word_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (dly_cnt == DLY_LAST) begin
                  pop_nxt   = '0;
                  state_nxt = S_POP;
                  if (!i_addr_empty)
                     miss_nxt = 1'b1;
               end else begin
                  dly_nxt = dly_cnt + 1'b1;
               end
            end
            S_POP: begin
               if (pop_cnt == POP_RDY) begin
                  if (i_data_empty)
                     state_nxt = S_DONE;
               end else begin
                  pop_nxt = pop_cnt + 1'b1;
               end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ABORT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign o_reg_clear   = (state == S_CLEAR) || (state == S_ABORT);
   assign o_ag_en       = (state == S_GEN);
   assign o_row_id      = (state == S_GEN) ? row_cnt : '0;
   assign o_ac_en       = (state == S_READ) || (state == S_DRAIN);
   assign o_sram_rd_en  = (state == S_READ);
   assign o_sram_addr   = (state == S_READ) ?
                          base_q + SRAM_ADDR_WIDTH'(word_cnt) : '0;
   assign o_miso_pop_en = (state == S_POP);
   assign o_busy        = (state != S_IDLE);
   assign o_done        = (state == S_DONE);
   assign o_miss        = miss_q;

`ifdef ROW_GROUP_CTRL_PERF_EN
   logic [15:0] cyc_read_q, cyc_pop_q;
   logic        early_q, early_hit;

   assign early_hit = (state == S_READ) && !i_abort && word_cnt != '0 &&
                      i_addr_empty && word_cnt != last_word;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         cyc_read_q <= '0;
         cyc_pop_q  <= '0;
         early_q    <= 1'b0;
      end else if (state == S_IDLE && i_start) begin
         cyc_read_q <= '0;
         cyc_pop_q  <= '0;
         early_q    <= 1'b0;
      end else begin
         if (o_ac_en && cyc_read_q != 16'hFFFF)
            cyc_read_q <= cyc_read_q + 16'd1;
         if (o_miso_pop_en && cyc_pop_q != 16'hFFFF)
            cyc_pop_q <= cyc_pop_q + 16'd1;
         if (early_hit)
            early_q <= 1'b1;
      end
   end

   assign o_cyc_read   = cyc_read_q;
   assign o_cyc_pop    = cyc_pop_q;
   assign o_early_exit = early_q;
`endif

endmodule

// File: tb/tb_row_group_ctrl.sv
// Testbench for row_group_ctrl: directed and random tiles checked against
// per-tile expectations computed from counts, addresses and sticky miss rules.
module tb_row_group_ctrl;

   localparam int RC = 4;
   localparam int SL = 1;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] base_addr = '0;
   logic [7:0] tile_words = '0;
   logic       ag_valid = 1'b0;
   logic       addr_empty = 1'b0;
   logic       data_empty = 1'b0;

   logic          o_reg_clear, o_ag_en, o_ac_en, o_sram_rd_en;
   logic [RC-1:0] o_row_id;
   logic [7:0]    o_sram_addr;
   logic          o_miso_pop_en, o_busy, o_done, o_miss;
`ifdef ROW_GROUP_CTRL_PERF_EN
   logic [15:0]   o_cyc_read, o_cyc_pop;
   logic          o_early_exit;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   row_group_ctrl #(
      .ROUTER_COUNT(RC), .SRAM_ADDR_WIDTH(8),
      .WORD_CNT_WIDTH(8), .SRAM_LATENCY(SL)
   ) dut (
      .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_abort(abort),
      .i_base_addr(base_addr), .i_tile_words(tile_words),
      .i_ag_valid(ag_valid), .i_addr_empty(addr_empty),
      .i_data_empty(data_empty),
      .o_reg_clear(o_reg_clear), .o_ag_en(o_ag_en), .o_row_id(o_row_id),
      .o_ac_en(o_ac_en), .o_sram_rd_en(o_sram_rd_en),
      .o_sram_addr(o_sram_addr), .o_miso_pop_en(o_miso_pop_en),
      .o_busy(o_busy), .o_done(o_done), .o_miss(o_miss)
`ifdef ROW_GROUP_CTRL_PERF_EN
     ,.o_cyc_read(o_cyc_read), .o_cyc_pop(o_cyc_pop),
      .o_early_exit(o_early_exit)
`endif
   );

   function automatic logic [19:0] outs();
      return {o_reg_clear, o_ag_en, o_row_id, o_ac_en, o_sram_rd_en,
              o_sram_addr, o_miso_pop_en, o_busy, o_done, o_miss};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // abort_rd >= 0 aborts during the read of that word index
   task automatic run_tile(input string t, input logic [7:0] base,
                           input int words, input int e_read,
                           input bit drain_empty, input int d_pop,
                           input int abort_rd);
      logic [7:0] addrs[$];
      int rows[$];
      int n_clr = 0, n_drain = 0, n_pop = 0, n_done = 0, rd_seen = 0;
      int exp_reads, exp_pop, exp_drain, sig;
      bit miss_first, miss_done = 1'b0, exp_miss, ab;
      ab = (abort_rd >= 0);
      start = 1'b1;
      base_addr = base;
      tile_words = 8'(words);
      step();
      start = 1'b0;
      miss_first = o_miss;
      for (int cyc = 0; cyc < 400 && o_busy; cyc++) begin
         if (o_reg_clear) n_clr++;
         if (o_sram_rd_en) begin
            addrs.push_back(o_sram_addr);
            rd_seen++;
         end
         if (o_ac_en && !o_sram_rd_en) n_drain++;
         if (o_miso_pop_en) n_pop++;
         if (o_done) begin
            n_done++;
            miss_done = o_miss;
         end
         ag_valid = o_ag_en && ($urandom_range(0, 2) != 0);
         if (ag_valid) rows.push_back(int'(o_row_id));
         if (o_sram_rd_en)
            addr_empty = (e_read != 0 && rd_seen >= e_read);
         else if (o_ac_en)
            addr_empty = drain_empty;
         else
            addr_empty = 1'($urandom);
         data_empty = o_miso_pop_en ? (n_pop - 1 >= d_pop) : 1'($urandom);
         abort = o_sram_rd_en && (rd_seen - 1 == abort_rd);
         start = 1'($urandom);
         step();
      end
      start = 1'b0;
      abort = 1'b0;
      ag_valid = 1'b0;
      chk({t, "/timeout"}, 32'(o_busy), 0);

      if (ab) exp_reads = abort_rd + 1;
      else if (words == 0) exp_reads = 0;
      else if (e_read == 0) exp_reads = words;
      else exp_reads = (words < (e_read > 2 ? e_read : 2)) ?
                       words : (e_read > 2 ? e_read : 2);
      exp_drain = (ab || words == 0) ? 0 : SL + 1;
      exp_pop   = ab ? 0 : ((d_pop > RC ? d_pop : RC) + 1);
      exp_miss  = (words == 0) || !drain_empty;

      sig = 0;
      foreach (rows[i]) sig = sig | (rows[i] << (4 * i));
      chk({t, "/clear_cycles"}, n_clr, ab ? 2 : 1);
      chk({t, "/rows_n"}, rows.size(), RC);
      chk({t, "/row_ids"}, sig, 32'h3210);
      chk({t, "/reads_n"}, addrs.size(), exp_reads);
      foreach (addrs[i])
         if (i < exp_reads)
            chk($sformatf("%s/addr%0d", t, i), addrs[i], 8'(base + i));
      chk({t, "/drain_cycles"}, n_drain, exp_drain);
      chk({t, "/pop_cycles"}, n_pop, exp_pop);
      chk({t, "/done_pulses"}, n_done, ab ? 0 : 1);
      chk({t, "/miss_cleared"}, 32'(miss_first), 0);
      if (!ab) begin
         chk({t, "/miss_done"}, 32'(miss_done), 32'(exp_miss));
         step();
         chk({t, "/miss_hold"}, 32'(o_miss), 32'(exp_miss));
      end
      step();
   endtask

   initial begin
      int w, ar;
      #1;
      chk("reset_outs", 32'(outs()), 0);
      step();
      nrst = 1'b1;
      step();
      chk("idle_outs", 32'(outs()), 0);

      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("idle_abort_ignored", 32'(o_busy), 0);

      run_tile("nominal", 8'h10, 3, 0, 1'b1, 6, -1);
      run_tile("early_exit", 8'h10, 8, 3, 1'b1, 5, -1);
      run_tile("miss_w2", 8'h10, 2, 0, 1'b0, 4, -1);
      run_tile("after_miss", 8'h20, 2, 0, 1'b1, 4, -1);
      run_tile("zero_len", 8'h30, 0, 0, 1'b1, 2, -1);
      run_tile("pop_mask", 8'h40, 1, 0, 1'b1, 0, -1);
      run_tile("early_c1", 8'h50, 5, 1, 1'b1, 3, -1);
      run_tile("abort_rd", 8'h10, 6, 0, 1'b1, 4, 1);
      run_tile("wrap", 8'hFE, 3, 0, 1'b1, 4, -1);

      for (int k = 0; k < 20; k++)
         run_tile($sformatf("rnd%0d", k), 8'($urandom),
                  $urandom_range(0, 10), $urandom_range(0, 6),
                  1'($urandom), $urandom_range(0, 8), -1);
      for (int k = 0; k < 6; k++) begin
         w  = $urandom_range(2, 10);
         ar = $urandom_range(0, w - 1);
         run_tile($sformatf("rnd_abort%0d", k), 8'($urandom), w, 0,
                  1'b1, 3, ar);
      end

      start = 1'b1;
      base_addr = 8'h60;
      tile_words = 8'd2;
      step();
      start = 1'b0;
      for (int cyc = 0; cyc < 100 && !o_miso_pop_en; cyc++) begin
         ag_valid = o_ag_en;
         addr_empty = 1'b1;
         data_empty = 1'b0;
         step();
      end
      chk("rst_in_pop", 32'(o_miso_pop_en), 1);
      step();
      #2;
      nrst = 1'b0;
      #1;
      chk("async_rst_outs", 32'(outs()), 0);
      step();
      ag_valid = 1'b0;
      addr_empty = 1'b0;
      nrst = 1'b1;
      step();
      chk("post_rst_idle", 32'(outs()), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
